// File: rtl/rom_load_pkg.sv
// Shared constants and FSM state type for the ROM download sequencer.
package rom_load_pkg;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned HDR_BYTES  = 512;
    localparam logic [9:0]  HDR_DETECT = 10'd512;

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StLo,
        StHi,
        StWrite,
        StDone
    } rom_load_state_t;

endpackage

// File: rtl/rom_byte_packer.sv
// Packs stream bytes little-endian into a 16-bit word; an odd tail byte is zero-padded.
module rom_byte_packer
    import rom_load_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lo_en,
    input  logic        i_hi_en,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_word,
    output logic        o_word_valid
);

    logic [15:0] r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= 16'h0000;
        end else if (i_lo_en) begin
            r_word[7:0] <= i_byte;
            if (i_last) begin
                r_word[15:8] <= 8'h00;
            end
        end else if (i_hi_en) begin
            r_word[15:8] <= i_byte;
        end
    end

    // Word is complete on the edge that captures its final byte.
    assign o_word_valid = i_hi_en | (i_lo_en & i_last);
    assign o_word       = r_word;

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: strips an optional copier header and writes 16-bit words.
// Header stripping is built only when ROM_HEADER_STRIP_EN is defined.
module rom_load_ctrl #(
    parameter int unsigned ADDR_W    = rom_load_pkg::ADDR_W,
    parameter int unsigned HDR_BYTES = rom_load_pkg::HDR_BYTES
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       rom_file_size,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ack,
    output logic              downloading,
    output logic              busy,
    output logic              done
);

    import rom_load_pkg::*;

    localparam int unsigned SKIP_W = $clog2(HDR_BYTES);

    rom_load_state_t   r_state;
    rom_load_state_t   w_state_nxt;
    logic [31:0]       r_remain;
    logic [ADDR_W-1:0] r_addr;
    logic [SKIP_W-1:0] r_skip_cnt;

    logic        w_hdr;
    logic [31:0] w_payload;
    logic        w_lo_en;
    logic        w_hi_en;
    logic        w_last;
    logic        w_skip_end;
    logic        w_word_valid;
    logic [15:0] w_word;

`ifdef ROM_HEADER_STRIP_EN
    assign w_hdr = (rom_file_size[9:0] == HDR_DETECT);
`else
    assign w_hdr = 1'b0;
`endif

    assign w_payload  = rom_file_size - (w_hdr ? 32'(HDR_BYTES) : 32'd0);
    assign w_lo_en    = (r_state == StLo) && byte_valid;
    assign w_hi_en    = (r_state == StHi) && byte_valid;
    assign w_last     = (r_remain == 32'd1);
    assign w_skip_end = (r_skip_cnt == SKIP_W'(HDR_BYTES - 1));

    rom_byte_packer u_packer (
        .i_clk        (clk_mem),
        .i_rst_n      (reset_n),
        .i_lo_en      (w_lo_en),
        .i_hi_en      (w_hi_en),
        .i_last       (w_last),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                // A header-bearing file still has to drain its header bytes first.
                if (start) begin
                    if (w_hdr)                  w_state_nxt = StSkip;
                    else if (w_payload == 32'd0) w_state_nxt = StDone;
                    else                        w_state_nxt = StLo;
                end
            end
            StSkip: begin
                if (byte_valid && w_skip_end) begin
                    w_state_nxt = (r_remain == 32'd0) ? StDone : StLo;
                end
            end
            StLo: begin
                if (byte_valid) w_state_nxt = w_word_valid ? StWrite : StHi;
            end
            StHi: begin
                if (w_word_valid) w_state_nxt = StWrite;
            end
            StWrite: begin
                if (wr_ack) w_state_nxt = (r_remain == 32'd0) ? StDone : StLo;
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_remain   <= 32'd0;
            r_addr     <= '0;
            r_skip_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && start) begin
                r_remain   <= w_payload;
                r_addr     <= '0;
                r_skip_cnt <= '0;
            end
            if (r_state == StSkip && byte_valid) begin
                r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
            end
            if (w_lo_en || w_hi_en) begin
                r_remain <= r_remain - 32'd1;
            end
            if (r_state == StWrite && wr_ack) begin
                r_addr <= r_addr + ADDR_W'(2);
            end
        end
    end

    assign byte_ready  = (r_state == StSkip) || (r_state == StLo) || (r_state == StHi);
    assign wr_req      = (r_state == StWrite);
    assign wr_addr     = r_addr;
    assign wr_data     = w_word;
    assign downloading = (r_state != StIdle) && (r_state != StDone);
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StDone);

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed self-checking bench for rom_load_ctrl; expectations follow ROM_HEADER_STRIP_EN.
module tb_rom_load_ctrl;

    logic        clk_mem       = 1'b0;
    logic        reset_n       = 1'b0;
    logic        start         = 1'b0;
    logic [31:0] rom_file_size = 32'd0;
    logic        byte_valid    = 1'b0;
    logic [7:0]  byte_data     = 8'h00;
    logic        wr_ack        = 1'b0;
    logic        byte_ready;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        downloading;
    logic        busy;
    logic        done;

    rom_load_ctrl dut (
        .clk_mem       (clk_mem),
        .reset_n       (reset_n),
        .start         (start),
        .rom_file_size (rom_file_size),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .downloading   (downloading),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk_mem = ~clk_mem;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stream [0:2047];
    logic [24:0] log_addr [$];
    logic [15:0] log_data [$];
    int          edges_to_done;
    int          bytes_taken;
    bit          done_seen;
    bit          dl_seen;
    bit          hold_bad;
    bit          ready_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_stream(input int seed);
        for (int i = 0; i < 2048; i++) begin
            stream[i] = 8'((i * 37 + (i >> 8) * 11 + seed) & 255);
        end
    endtask

    // Word k of a load whose payload starts at stream offset 'base'.
    function automatic logic [15:0] exp_word(input int base, input int k);
        return {stream[base + 2 * k + 1], stream[base + 2 * k]};
    endfunction

    task automatic run_load(input int size, input int ack_delay, input int limit,
                            input int mid_start_at);
        int          idx      = 0;
        int          wait_cnt = 0;
        logic [24:0] h_addr   = '0;
        logic [15:0] h_data   = '0;
        log_addr.delete();
        log_data.delete();
        done_seen     = 0;
        dl_seen       = 0;
        hold_bad      = 0;
        ready_bad     = 0;
        edges_to_done = -1;
        @(negedge clk_mem);
        start         = 1'b1;
        rom_file_size = size;
        byte_valid    = 1'b1;
        byte_data     = stream[0];
        wr_ack        = (ack_delay == 0);
        @(posedge clk_mem);
        #1 start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk_mem);
            if (done) begin
                done_seen     = 1;
                edges_to_done = c - 1;
                break;
            end
            if (downloading) dl_seen = 1;
            start = (c == mid_start_at);
            if (start) rom_file_size = 32'd2;
            byte_valid = 1'b1;
            byte_data  = stream[idx % 2048];
            if (byte_ready) idx++;
            if (wr_req) begin
                if (byte_ready) ready_bad = 1;
                if (wait_cnt > 0 && (wr_addr !== h_addr || wr_data !== h_data)) hold_bad = 1;
                h_addr = wr_addr;
                h_data = wr_data;
                if (wait_cnt >= ack_delay) begin
                    wr_ack = 1'b1;
                    log_addr.push_back(wr_addr);
                    log_data.push_back(wr_data);
                    wait_cnt = 0;
                end else begin
                    wr_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wr_ack   = (ack_delay == 0);
                wait_cnt = 0;
            end
        end
        bytes_taken = idx;
        start      = 1'b0;
        byte_valid = 1'b0;
        wr_ack     = 1'b0;
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk_mem);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        fill_stream(0);
        repeat (2) @(posedge clk_mem);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_req", {31'd0, wr_req}, 32'd0);
        check("rst_wr_addr", {7'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_downloading", {31'd0, downloading}, 32'd0);
        @(negedge clk_mem);
        reset_n = 1'b1;

        // Odd-length file: last word zero-padded.
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
        stream[3] = 8'h44; stream[4] = 8'h55;
        run_load(5, 0, 100, 0);
        check("odd_done_seen", {31'd0, done_seen}, 32'd1);
        check("odd_latency", edges_to_done, 32'd8);
        check("odd_writes", log_addr.size(), 32'd3);
        check("odd_bytes", bytes_taken, 32'd5);
        if (log_addr.size() == 3) begin
            check("odd_w0", {log_addr[0], log_data[0]}, {25'd0, 16'h2211} & 32'hFFFF_FFFF);
            check("odd_a1", {7'd0, log_addr[1]}, 32'd2);
            check("odd_d1", {16'd0, log_data[1]}, 32'h4433);
            check("odd_a2", {7'd0, log_addr[2]}, 32'd4);
            check("odd_d2", {16'd0, log_data[2]}, 32'h0055);
        end
        check_idle_after("odd");

        // Full rate with ack tied high; a stray start mid-load must be ignored.
        fill_stream(3);
        run_load(16, 0, 200, 7);
        check("full_done_seen", {31'd0, done_seen}, 32'd1);
        check("full_latency", edges_to_done, 32'd24);
        check("full_writes", log_addr.size(), 32'd8);
        check("full_bytes", bytes_taken, 32'd16);
        if (log_addr.size() == 8) begin
            check("full_last_addr", {7'd0, log_addr[7]}, 32'hE);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("full_d%0d", k), {16'd0, log_data[k]}, {16'd0, exp_word(0, k)});
            end
        end
        check_idle_after("full");

        // Slow ack: request and word must hold, no bytes taken while waiting.
        fill_stream(9);
        run_load(6, 4, 200, 0);
        check("slow_done_seen", {31'd0, done_seen}, 32'd1);
        check("slow_latency", edges_to_done, 32'd21);
        check("slow_writes", log_addr.size(), 32'd3);
        check("slow_hold", {31'd0, hold_bad}, 32'd0);
        check("slow_ready_low", {31'd0, ready_bad}, 32'd0);
        if (log_addr.size() == 3) begin
            check("slow_d2", {log_addr[2], log_data[2]} & 32'hFFFF_FFFF,
                  {25'd4, exp_word(0, 2)} & 32'hFFFF_FFFF);
        end

        // Empty file.
        run_load(0, 0, 20, 0);
        check("empty_done_seen", {31'd0, done_seen}, 32'd1);
        check("empty_latency", edges_to_done, 32'd0);
        check("empty_writes", log_addr.size(), 32'd0);
        check("empty_no_dl", {31'd0, dl_seen}, 32'd0);
        check_idle_after("empty");

        // 0x600 bytes: low ten bits of the size flag a copier header.
        fill_stream(21);
        run_load(32'h600, 0, 3000, 0);
        check("hdr_done_seen", {31'd0, done_seen}, 32'd1);
        check("hdr_bytes", bytes_taken, 32'h600);
`ifdef ROM_HEADER_STRIP_EN
        check("hdr_writes", log_addr.size(), 32'd512);
        check("hdr_latency", edges_to_done, 32'd2048);
        if (log_addr.size() == 512) begin
            check("hdr_first_addr", {7'd0, log_addr[0]}, 32'd0);
            check("hdr_first_data", {16'd0, log_data[0]}, {16'd0, exp_word(32'h200, 0)});
            check("hdr_last_addr", {7'd0, log_addr[511]}, 32'h3FE);
        end
`else
        check("hdr_writes", log_addr.size(), 32'd768);
        check("hdr_latency", edges_to_done, 32'd2304);
        if (log_addr.size() == 768) begin
            check("hdr_first_addr", {7'd0, log_addr[0]}, 32'd0);
            check("hdr_first_data", {16'd0, log_data[0]}, {16'd0, exp_word(0, 0)});
            check("hdr_last_addr", {7'd0, log_addr[767]}, 32'h5FE);
        end
`endif

        // Header-only file.
        run_load(512, 0, 1000, 0);
        check("hdronly_done_seen", {31'd0, done_seen}, 32'd1);
`ifdef ROM_HEADER_STRIP_EN
        check("hdronly_writes", log_addr.size(), 32'd0);
        check("hdronly_latency", edges_to_done, 32'd512);
`else
        check("hdronly_writes", log_addr.size(), 32'd256);
        check("hdronly_latency", edges_to_done, 32'd768);
`endif
        check_idle_after("hdronly");

        // Reset while word 10 is being assembled.
        fill_stream(5);
        run_load(40, 0, 28, 0);
        check("abort_writes", log_addr.size(), 32'd9);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dl", {31'd0, downloading}, 32'd0);
        check("abort_wr_req", {31'd0, wr_req}, 32'd0);
        check("abort_wr_addr", {7'd0, wr_addr}, 32'd0);
        check("abort_wr_data", {16'd0, wr_data}, 32'd0);
        check("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk_mem);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_mem);
        check("abort_no_done", {31'd0, done}, 32'd0);

        // Fresh load after the abort starts from address 0.
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
        stream[3] = 8'h44; stream[4] = 8'h55;
        run_load(5, 0, 100, 0);
        check("reload_writes", log_addr.size(), 32'd3);
        if (log_addr.size() == 3) begin
            check("reload_a0", {7'd0, log_addr[0]}, 32'd0);
            check("reload_d0", {16'd0, log_data[0]}, 32'h2211);
            check("reload_d2", {16'd0, log_data[2]}, 32'h0055);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
